// File: rtl/matrix_load_ctrl.sv
`timescale 1ns/1ps
// Collects four UART bytes into a 32-bit word and commits it to matrix A or B,
// with per-byte idle timeout, abort, and independent matrix clears.
module matrix_load_ctrl #(
  parameter int TIMEOUT = 50000000,
  parameter int TMO_W   = 26
) (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        load_start,
  input  logic        sel_b,
  input  logic        load_abort,
  input  logic        clr_a,
  input  logic        clr_b,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [31:0] matrix_a,
  output logic [31:0] matrix_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rx_clear,
  output logic [2:0]  byte_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, DONE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state;
  logic [31:0]      shift;
  logic             tgt;
  logic [TMO_W-1:0] timer;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state    <= IDLE;
      matrix_a <= '0;
      matrix_b <= '0;
      shift    <= '0;
      tgt      <= 1'b0;
      timer    <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rx_clear <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rx_clear <= 1'b0;
      case (state)
        IDLE: begin
          // Clears and a load start may coincide; both take effect.
          if (clr_a) matrix_a <= '0;
          if (clr_b) matrix_b <= '0;
          if (load_start) begin
            state    <= COLLECT;
            tgt      <= sel_b;
            shift    <= '0;
            byte_cnt <= '0;
            timer    <= '0;
            rx_clear <= 1'b1;
            busy     <= 1'b1;
          end
        end
        COLLECT: begin
          // Abort outranks a byte; a byte arriving on the expiry cycle outranks the timeout.
          if (load_abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            byte_cnt <= '0;
          end else if (rx_valid) begin
            shift    <= {shift[23:0], rx_byte};
            byte_cnt <= byte_cnt + 3'd1;
            timer    <= '0;
            if (byte_cnt == 3'd3) state <= COMMIT;
          end else if (timer == TMO_LAST) begin
            state    <= IDLE;
            err      <= 1'b1;
            busy     <= 1'b0;
            byte_cnt <= '0;
          end else begin
            timer <= timer + TMO_W'(1);
          end
        end
        COMMIT: begin
          if (load_abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            byte_cnt <= '0;
          end else begin
            if (tgt) matrix_b <= shift;
            else     matrix_a <= shift;
            state    <= DONE;
            done     <= 1'b1;
            rx_clear <= 1'b1;
            busy     <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          byte_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for matrix_load_ctrl: vector table, directed corner
// sequences and randomized loads against a transaction-level matrix model.
module tb_matrix_load_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0, load_start = 1'b0, sel_b = 1'b0, load_abort = 1'b0;
  logic        clr_a = 1'b0, clr_b = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [31:0] matrix_a, matrix_b;
  logic        busy, done, err, rx_clear;
  logic [2:0]  byte_cnt;

  always #10 clk = ~clk;

  matrix_load_ctrl #(.TIMEOUT(TMO), .TMO_W(5)) dut (
    .CLK_50M(clk), .reset(reset), .load_start(load_start), .sel_b(sel_b),
    .load_abort(load_abort), .clr_a(clr_a), .clr_b(clr_b), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .matrix_a(matrix_a), .matrix_b(matrix_b), .busy(busy),
    .done(done), .err(err), .rx_clear(rx_clear), .byte_cnt(byte_cnt)
  );

  typedef struct {
    bit          sel;
    logic [31:0] word;
    int          nb;
    int          abort_at;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t        vecs [8];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic chk_mats(input string name);
    chk({name, "_a"}, matrix_a, exp_a);
    chk({name, "_b"}, matrix_b, exp_b);
  endtask

  // One complete load. nb<4 ends in a timeout; abort_at 0..3 aborts with that
  // byte, 4 aborts in the commit cycle, -1 never aborts.
  task automatic run_load(input bit sel, input logic [31:0] w, input int nb,
                          input int abort_at, input int gmin, input int gmax,
                          input bit ca, input bit cb);
    int cnt;
    int g;
    load_start = 1'b1; sel_b = sel; clr_a = ca; clr_b = cb;
    tick;
    load_start = 1'b0; sel_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    if (ca) exp_a = '0;
    if (cb) exp_b = '0;
    chk("start_rx_clear", 32'(rx_clear), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk_mats("start_clr");
    for (int i = 0; i < nb; i++) begin
      g = $urandom_range(gmax, gmin);
      repeat (g) tick;
      rx_valid = 1'b1; rx_byte = w[31-8*i -: 8]; load_abort = (abort_at == i);
      tick;
      rx_valid = 1'b0; load_abort = 1'b0;
      if (abort_at == i) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_cnt", 32'(byte_cnt), 32'd0);
        tick;
        chk("abort_done", 32'(done), 32'd0);
        chk_mats("abort");
        return;
      end
      chk("byte_cnt", 32'(byte_cnt), 32'(i + 1));
      chk("collect_err", 32'(err), 32'd0);
    end
    if (nb == 4) begin
      if (abort_at == 4) begin
        load_abort = 1'b1;
        tick;
        load_abort = 1'b0;
        chk("cabort_busy", 32'(busy), 32'd0);
        chk("cabort_done", 32'(done), 32'd0);
        chk_mats("cabort");
        return;
      end
      chk("commit_busy", 32'(busy), 32'd1);
      chk("commit_done", 32'(done), 32'd0);
      tick;
      if (sel) exp_b = w;
      else     exp_a = w;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_rx_clear", 32'(rx_clear), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk_mats("commit");
      tick;
      chk("done_len", 32'(done), 32'd0);
      chk("rx_clear_len", 32'(rx_clear), 32'd0);
      chk("idle_cnt", 32'(byte_cnt), 32'd0);
    end else begin
      cnt = 0;
      while (err !== 1'b1 && cnt < 40) begin
        tick;
        cnt++;
      end
      chk("timeout_cycles", 32'(cnt), 32'(TMO));
      chk("timeout_busy", 32'(busy), 32'd0);
      chk("timeout_cnt", 32'(byte_cnt), 32'd0);
      chk_mats("timeout");
      tick;
      chk("err_len", 32'(err), 32'd0);
    end
  endtask

  task automatic do_clear(input bit a, input bit b);
    clr_a = a; clr_b = b;
    tick;
    clr_a = 1'b0; clr_b = 1'b0;
    if (a) exp_a = '0;
    if (b) exp_b = '0;
    chk_mats("clear");
  endtask

  task automatic stray_rx;
    rx_valid = 1'b1; rx_byte = 8'($urandom);
    tick;
    rx_valid = 1'b0;
    chk("stray_cnt", 32'(byte_cnt), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    tick;
    chk("stray_busy2", 32'(busy), 32'd0);
    chk_mats("stray");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'h12345678, 4, -1, 32'h12345678, 32'h00000000};
    vecs[1] = '{1, 32'hCAFEF00D, 4, -1, 32'h12345678, 32'hCAFEF00D};
    vecs[2] = '{0, 32'hDEADBEEF, 4, -1, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1, 32'h11223344, 4,  3, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1, 32'h55667788, 4,  4, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1, 32'h0BADF00D, 2, -1, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[6] = '{1, 32'h00000001, 4, -1, 32'hDEADBEEF, 32'h00000001};
    vecs[7] = '{0, 32'hA5A5A5A5, 0, -1, 32'hDEADBEEF, 32'h00000001};

    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("rst_a", matrix_a, 32'd0);
    chk("rst_b", matrix_b, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_clear", 32'(rx_clear), 32'd0);
    chk("rst_cnt", 32'(byte_cnt), 32'd0);

    for (int v = 0; v < 8; v++) begin
      run_load(vecs[v].sel, vecs[v].word, vecs[v].nb, vecs[v].abort_at, 0, 3, 1'b0, 1'b0);
      chk("vec_a", matrix_a, vecs[v].exp_a);
      chk("vec_b", matrix_b, vecs[v].exp_b);
    end

    stray_rx;
    do_clear(1'b1, 1'b1);
    // Every byte arrives on the cycle the idle timer would otherwise expire.
    run_load(1'b0, 32'h13579BDF, 4, -1, TMO - 1, TMO - 1, 1'b0, 1'b0);
    run_load(1'b1, 32'h2468ACE0, 4, -1, 0, 0, 1'b0, 1'b0);
    run_load(1'b1, 32'h0F0F0F0F, 4, -1, 0, 1, 1'b1, 1'b1);

    // Clears and restarts are ignored mid-load.
    load_start = 1'b1; sel_b = 1'b1;
    tick;
    load_start = 1'b0; sel_b = 1'b0;
    clr_a = 1'b1; clr_b = 1'b1; load_start = 1'b1;
    tick;
    clr_a = 1'b0; clr_b = 1'b0; load_start = 1'b0;
    chk_mats("collect_clr");
    chk("collect_restart_rxc", 32'(rx_clear), 32'd0);
    load_abort = 1'b1;
    tick;
    load_abort = 1'b0;
    chk("collect_abort_busy", 32'(busy), 32'd0);

    // Reset in the middle of a load.
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1; rx_byte = 8'h5A;
      tick;
    end
    rx_valid = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_a = '0; exp_b = '0;
    chk_mats("midrst");
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(byte_cnt), 32'd0);
    chk("midrst_done", 32'(done | err | rx_clear), 32'd0);
    run_load(1'b0, 32'hAABBCCDD, 4, -1, 0, 2, 1'b0, 1'b0);
    chk("after_rst_a", matrix_a, 32'hAABBCCDD);

    for (int r = 0; r < 40; r++) begin
      int op;
      int nb;
      int ab;
      op = $urandom_range(3, 0);
      if (op <= 1) begin
        nb = ($urandom_range(9, 0) > 1) ? 4 : $urandom_range(3, 0);
        ab = ($urandom_range(7, 0) == 0) ? $urandom_range(4, 0) : -1;
        run_load(1'($urandom), $urandom, nb, ab, 0, TMO - 1,
                 ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
      end else if (op == 2) begin
        do_clear(1'($urandom), 1'($urandom));
      end else begin
        stray_rx;
      end
      chk_mats("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_load_ctrl.md
MATRIX_LOAD_CTRL -- requirements
Module: matrix_load_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000000: max idle clocks between accepted bytes during a load.
REQ-002 SHALL have parameter TMO_W, default 26: width of the timeout counter; TIMEOUT SHALL be less than 2**TMO_W.
REQ-003 CLK_50M  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_start  input  1  one-cycle pulse: begin loading a 32-bit word.
REQ-006 sel_b  input  1  target select, sampled with load_start: 0 = matrix A, 1 = matrix B.
REQ-007 load_abort  input  1  one-cycle pulse: cancel an in-progress load.
REQ-008 clr_a, clr_b  input  1 each  one-cycle pulses: zero matrix A / matrix B.
REQ-009 rx_valid  input  1  one-cycle pulse: rx_byte holds a new received byte.
REQ-010 rx_byte  input  8  received UART byte.
REQ-011 matrix_a, matrix_b  output  32 each  registered matrix operands for the calculator.
REQ-012 busy  output  1  high while a load is in progress.
REQ-013 done  output  1  one-cycle pulse: a word was committed.
REQ-014 err  output  1  one-cycle pulse: a load ended by timeout.
REQ-015 rx_clear  output  1  one-cycle pulse: request that the UART receive buffer flush.
REQ-016 byte_cnt  output  3  bytes accepted in the current load, 0..4.

Function
REQ-017 SHALL implement the states IDLE, COLLECT, COMMIT, and DONE.
REQ-018 IDLE: load_start -> COLLECT next cycle; latch sel_b into tgt; clear shift register, byte_cnt, and timer; pulse rx_clear in that cycle.
REQ-019 IDLE: ignore rx_valid; when clr_a or clr_b is high, zero the matching matrix next cycle; both high -> zero both.
REQ-020 IDLE priority: when load_start and any clr arrive in the same cycle, perform the clear AND start the load.
REQ-021 COLLECT: on rx_valid, shift = {shift[23:0], rx_byte} (first byte ends in bits 31:24); byte_cnt +1; timer reset to 0.
REQ-022 COLLECT: rx_valid with byte_cnt==3 -> COMMIT next cycle with byte_cnt=4.
REQ-023 COLLECT: no rx_valid -> timer +1; timer reaching TIMEOUT-1 without rx_valid -> IDLE next cycle, err pulse that cycle, matrices unchanged.
REQ-024 COLLECT: rx_valid in the same cycle the timer would expire -> accept the byte; no timeout.
REQ-025 COLLECT/COMMIT: load_abort -> IDLE next cycle, no write, no err; abort wins over a simultaneous rx_valid or commit.
REQ-026 COLLECT: ignore load_start and clr_a/clr_b (no restart, no clear).
REQ-027 COMMIT (one cycle): write shift to matrix_a (tgt=0) or matrix_b (tgt=1); the other matrix is untouched; -> DONE.
REQ-028 DONE (one cycle): done=1, rx_clear=1; -> IDLE; byte_cnt returns to 0 on entry to IDLE.
REQ-029 busy SHALL be 1 in COLLECT and COMMIT and 0 in IDLE and DONE.
REQ-030 Latency SHALL be: 4th rx_valid at edge N -> matrix updated at edge N+1 -> done high during cycle N+2.
REQ-031 All outputs SHALL be registered; done, err, and rx_clear SHALL never be high for more than one consecutive cycle.

Reset
REQ-032 reset SHALL force, at the next edge: state=IDLE, matrix_a=0, matrix_b=0, shift=0, tgt=0, timer=0, byte_cnt=0, busy=0, done=0, err=0, rx_clear=0.
REQ-033 reset SHALL take priority over all other inputs, including mid-load (no partial write, no done or err pulse).

Verification
REQ-034 load_start (sel_b=0), rx bytes 12,34,56,78 -> matrix_a=32'h12345678, matrix_b unchanged, one done pulse, one rx_clear pulse at start and one at done.
REQ-035 With TIMEOUT=16: load_start (sel_b=1), 2 bytes, then silence -> err pulse exactly 16 cycles after the last byte, matrix_b unchanged, busy=0.
REQ-036 Load A to 32'hDEADBEEF, then load_start (sel_b=1) with 3 bytes, then load_abort in the same cycle as the 4th rx_valid -> both matrices unchanged, no done.
REQ-037 clr_a and clr_b in the same cycle in IDLE with both matrices nonzero -> both 0 next cycle; clr_a during COLLECT -> ignored.
REQ-038 reset asserted after 2 bytes of a load -> all outputs 0 next cycle; a following 4-byte load of AA,BB,CC,DD -> matrix_a=32'hAABBCCDD.
REQ-039 rx_valid while in IDLE with no load_start -> no state change, byte_cnt stays 0.
